// File: rtl/check_collision.sv
// Maze-wall collision checker for one 16x16 sprite, plus the shared free-running clkdiv counter.
// Optional pillar walls are compiled in with `define COLLIDE_PILLARS_EN.
module check_collision #(
    parameter int FIELD_X0  = 80,
    parameter int FIELD_Y0  = 16,
    parameter int COLS      = 30,
    parameter int ROWS      = 28,
    parameter int TILE_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [8:0]  PacY,
    input  logic [1:0]  state,
    output logic        result,
    output logic [31:0] clkdiv
);
    // No handshake: inputs are sampled on every rising edge and result follows one clock later.

    localparam int S = 1 << TILE_LOG2;
    localparam logic signed [11:0] S12  = 12'(S);
    localparam logic signed [11:0] X_LO = 12'(FIELD_X0);
    localparam logic signed [11:0] X_HI = 12'(FIELD_X0 + COLS * S - 1);
    localparam logic signed [11:0] Y_LO = 12'(FIELD_Y0);
    localparam logic signed [11:0] Y_HI = 12'(FIELD_Y0 + ROWS * S - 1);

    // Negative probes fall below X_LO/Y_LO, so the range test also covers underflow.
    function automatic logic is_wall(input logic signed [11:0] px, input logic signed [11:0] py);
        logic [11:0] tx;
        logic [11:0] ty;
        is_wall = 1'b0;
        tx = '0;
        ty = '0;
        if (px < X_LO || px > X_HI || py < Y_LO || py > Y_HI) begin
            is_wall = 1'b1;
        end else begin
            tx = 12'(px - X_LO) >> TILE_LOG2;
            ty = 12'(py - Y_LO) >> TILE_LOG2;
            if (tx == 12'd0 || tx == 12'(COLS - 1) || ty == 12'd0 || ty == 12'(ROWS - 1))
                is_wall = 1'b1;
`ifdef COLLIDE_PILLARS_EN
            if (tx[1:0] == 2'd2 && ty[1:0] == 2'd2)
                is_wall = 1'b1;
`endif
        end
    endfunction

    logic signed [11:0] x0, y0;
    logic signed [11:0] xa, ya, xb, yb;
    logic               free_next;

    always_comb begin
        x0 = signed'({2'b00, PacX});
        y0 = signed'({3'b000, PacY});
        xa = x0;
        ya = y0;
        xb = x0;
        yb = y0;
        case (state)
            2'b00: begin ya = y0 - 12'sd1; xb = x0 + S12 - 12'sd1; yb = y0 - 12'sd1; end
            2'b01: begin ya = y0 + S12;    xb = x0 + S12 - 12'sd1; yb = y0 + S12;    end
            2'b10: begin xa = x0 - 12'sd1; xb = x0 - 12'sd1;       yb = y0 + S12 - 12'sd1; end
            default: begin xa = x0 + S12;  xb = x0 + S12;          yb = y0 + S12 - 12'sd1; end
        endcase
        free_next = ~(is_wall(xa, ya) | is_wall(xb, yb));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= 1'b0;
            clkdiv <= '0;
        end else begin
            result <= free_next;
            clkdiv <= clkdiv + 32'd1;
        end
    end

endmodule

// File: tb/tb_check_collision.sv
// Self-checking bench for check_collision: tile-map reference model, per-cycle compare, literal pins.
module tb_check_collision;
    logic        clk;
    logic        rst;
    logic [9:0]  PacX;
    logic [8:0]  PacY;
    logic [1:0]  state;
    logic        result;
    logic [31:0] clkdiv;

    int checks = 0;
    int errors = 0;

    logic [0:0]  exp_q[$];
    logic [31:0] exp_div = '0;

    check_collision dut (
        .clk(clk), .rst(rst), .PacX(PacX), .PacY(PacY),
        .state(state), .result(result), .clkdiv(clkdiv)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pixel is a wall if outside the 30x28 tile field, on the border ring,
    // or (when enabled) on a pillar tile.
    function automatic bit m_wall(int px, int py);
        int tx, ty;
        if (px < 80 || px >= 80 + 30 * 16 || py < 16 || py >= 16 + 28 * 16) return 1'b1;
        tx = (px - 80) / 16;
        ty = (py - 16) / 16;
        if (tx == 0 || tx == 29 || ty == 0 || ty == 27) return 1'b1;
`ifdef COLLIDE_PILLARS_EN
        if (tx % 4 == 2 && ty % 4 == 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_free(int x, int y, int s);
        case (s)
            0: return !(m_wall(x, y - 1) || m_wall(x + 15, y - 1));
            1: return !(m_wall(x, y + 16) || m_wall(x + 15, y + 16));
            2: return !(m_wall(x - 1, y) || m_wall(x - 1, y + 15));
            default: return !(m_wall(x + 16, y) || m_wall(x + 16, y + 15));
        endcase
    endfunction

    // Model update on each active edge
    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back(m_free(int'(PacX), int'(PacY), int'(state)));
            exp_div = exp_div + 32'd1;
        end
    end

    always @(negedge rst) begin
        exp_q.delete();
        exp_div = '0;
    end

    // Scoreboard compare away from the active edge
    always @(negedge clk) begin
        logic [0:0] e;
        if (!rst) begin
            checks++;
            if (result !== 1'b0 || clkdiv !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold: result=%b clkdiv=%0d required result=0 clkdiv=0", result, clkdiv);
            end
        end else begin
            checks++;
            if (clkdiv !== exp_div) begin
                errors++;
                $display("FAIL clkdiv: got %0d required %0d", clkdiv, exp_div);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (result !== e[0]) begin
                    errors++;
                    $display("FAIL result_model: got %b required %b (PacX=%0d PacY=%0d state=%0d)",
                             result, e[0], PacX, PacY, state);
                end
            end
        end
    end

    // Driver tasks
    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic drive(input int x, input int y, input int s);
        @(negedge clk);
        PacX  = 10'(x);
        PacY  = 9'(y);
        state = 2'(s);
    endtask

    task automatic step_expect(input string name, input int x, input int y, input int s, input bit req);
        drive(x, y, s);
        @(negedge clk);
        check_lit(name, 32'(result), 32'(req));
    endtask

    initial begin
        rst = 1'b0;
        PacX = 10'd200;
        PacY = 9'd146;
        state = 2'b00;

        repeat (3) @(negedge clk);
        check_lit("reset_result", 32'(result), 32'd0);
        check_lit("reset_clkdiv", clkdiv, 32'd0);

        rst = 1'b1;
        @(negedge clk); check_lit("div_1", clkdiv, 32'd1);
        @(negedge clk); check_lit("div_2", clkdiv, 32'd2);
        @(negedge clk); check_lit("div_3", clkdiv, 32'd3);

        step_expect("open_up",    200, 146, 0, 1'b1);
        step_expect("open_down",  200, 146, 1, 1'b1);
        step_expect("open_left",  200, 146, 2, 1'b1);
        step_expect("open_right", 200, 146, 3, 1'b1);

        step_expect("border_left",  96, 146, 2, 1'b0);
        step_expect("border_right_free", 96, 146, 3, 1'b1);
        step_expect("border_top",   200, 32, 0, 1'b0);
        step_expect("border_far_right", 528, 146, 3, 1'b0);

`ifdef COLLIDE_PILLARS_EN
        step_expect("pillar_up", 112, 64, 0, 1'b0);
`else
        step_expect("pillar_up", 112, 64, 0, 1'b1);
`endif

        for (int s = 0; s < 4; s++) step_expect("origin_underflow", 0, 0, s, 1'b0);
        step_expect("max_coord_right", 1023, 511, 3, 1'b0);

        // Latency: new direction is not visible until after the next edge
        step_expect("latency_pre", 96, 146, 2, 1'b0);
        drive(96, 146, 3);
        #1 check_lit("latency_hold", 32'(result), 32'd0);
        @(negedge clk);
        check_lit("latency_after", 32'(result), 32'd1);

        // Asynchronous reset mid-count
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_lit("async_rst_div", clkdiv, 32'd0);
        check_lit("async_rst_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Randomized stimulus, mostly around the field, sometimes anywhere
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                drive($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 3));
            else
                drive($urandom_range(60, 580), $urandom_range(0, 480), $urandom_range(0, 3));
        end
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
